// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the bridge sink/source side and the sink SRAM slave.
package ahb_pkg;

  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_NONSEQ = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2,
    StSleep
  } sram_state_e;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// Maps an AHB transfer size and the low address bits onto 32-bit byte lanes.
module ahb_byte_strobe_gen
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  // Unsupported sizes give no lanes; the caller flags them as errors.
  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_i[0];
      end
      HSIZE_WORD: begin
        strb_o     = 4'b1111;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sink_sram_slave.sv
// Word-organised SRAM AHB-Lite slave on the bridge sink port, with wait states,
// two-cycle ERROR responses, write-to-read forwarding and a sleep handshake.
module ahb_sink_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  i_clk_sink,
  input  logic                  i_rstn_sink,
  input  logic                  i_hsel,
  input  logic                  i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  input  logic                  i_sleep_req,
  output logic                  o_sleep_ack
);

  localparam int unsigned IdxWidth = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  sram_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hreadyout_q, hresp_q, sleep_ack_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [IdxWidth-1:0]   idx_q;
  logic [2:0]            size_q;
  logic [1:0]            lane_q;
  logic                  wr_pend_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IdxWidth-1:0]   idx;
  logic                  accept, req_err, addr_err, size_err, misalign, commit;
  logic [3:0]            wr_strb, unused_req_strb;
  logic                  unused_wr_misalign;
  logic [DATA_WIDTH-1:0] rd_word;

  assign offset   = i_haddr - BASE_ADDR;
  assign idx      = offset[IdxWidth+1:2];
  assign addr_err = (i_haddr < BASE_ADDR) ||
                    ({2'b00, offset[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH));
  assign size_err = i_hsize > HSIZE_WORD;
  assign req_err  = addr_err | size_err | misalign | (state_q == StSleep);
  assign accept   = i_hsel & (i_htrans == HTRANS_NONSEQ) & i_hready & hreadyout_q;
  // A pending write lands on the edge that ends its completing (ready) cycle.
  assign commit   = wr_pend_q & hreadyout_q;

  ahb_byte_strobe_gen u_req_strb (
    .hsize_i    (i_hsize),
    .addr_i     (offset[1:0]),
    .strb_o     (unused_req_strb),
    .misalign_o (misalign)
  );

  ahb_byte_strobe_gen u_wr_strb (
    .hsize_i    (size_q),
    .addr_i     (lane_q),
    .strb_o     (wr_strb),
    .misalign_o (unused_wr_misalign)
  );

  // Read data merged with a write committing to the same word on this edge.
  always_comb begin
    rd_word = mem[idx];
    if (commit && (idx_q == idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StErr2, StSleep: begin
        if (accept) begin
          if (req_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StIdle;
          end
        end else if (i_sleep_req) begin
          state_d = StSleep;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      sleep_ack_q <= 1'b0;
      idx_q       <= '0;
      size_q      <= '0;
      lane_q      <= '0;
      wr_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= !(state_d inside {StWait, StErr1});
      hresp_q     <= (state_d inside {StErr1, StErr2}) ? HRESP_ERROR : HRESP_OKAY;
      // Ack stays up across an ERROR taken while asleep.
      sleep_ack_q <= (state_q == StSleep) |
                     (sleep_ack_q & (state_q inside {StErr1, StErr2}));
      if (accept) begin
        idx_q     <= idx;
        size_q    <= i_hsize;
        lane_q    <= offset[1:0];
        wr_pend_q <= i_hwrite & ~req_err;
      end else if (commit) begin
        wr_pend_q <= 1'b0;
      end
      if (accept && !req_err && !i_hwrite) hrdata_q <= rd_word;
    end
  end

  always_ff @(posedge i_clk_sink) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[idx_q][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
  end

  assign o_hreadyout = hreadyout_q;
  assign o_hresp     = hresp_q;
  assign o_hrdata    = hrdata_q;
  assign o_sleep_ack = sleep_ack_q;

endmodule

// File: doc/ahb_sink_sram_slave.md
Name: ahb_sink_sram_slave

Overview:
- AHB-Lite slave that sits directly downstream of the bridge's sink-side master port.
- Consumes o_haddr/o_htrans/o_hsize/o_hwrite/o_hwdata from the bridge and returns hready/hresp/hrdata to it.
- Word-organised on-chip SRAM with configurable wait states, byte/halfword writes and AHB two-cycle ERROR responses.
- Provides a sleep req/ack handshake matching the bridge's sink sleep domain.

Parameters:
- ADDR_WIDTH, 32, width of i_haddr.
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words.
- BASE_ADDR, 0, byte address of word 0.
- WAIT_STATES, 1, number of hreadyout=0 cycles per OKAY data phase; range 0..15.

Ports:
- i_clk_sink  in  1  sink-domain clock; all logic on the rising edge.
- i_rstn_sink  in  1  asynchronous, active-low reset.
- i_hsel  in  1  slave select.
- i_htrans  in  1  1=NONSEQ, 0=IDLE (the bridge's 1-bit htrans).
- i_hsize  in  3  0=byte, 1=half, 2=word.
- i_hwrite  in  1  1=write.
- i_haddr  in  ADDR_WIDTH  byte address.
- i_hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- i_hready  in  1  bus hready (address phase is valid only when high).
- o_hreadyout  out  1  data-phase complete.
- o_hresp  out  1  0=OKAY, 1=ERROR.
- o_hrdata  out  DATA_WIDTH  read data.
- i_sleep_req  in  1  sleep request.
- o_sleep_ack  out  1  sleep acknowledge.

Behaviour:
- Reset values: o_hreadyout=1, o_hresp=0, o_hrdata=0, o_sleep_ack=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Address-phase accept: i_hsel & i_htrans & i_hready & o_hreadyout.
  - On accept, latch addr, size, write, and error flag.
- Error condition: any of
  - addr < BASE_ADDR;
  - word index >= MEM_DEPTH;
  - hsize > 2;
  - misaligned access (half with addr[0]=1, word with addr[1:0]!=0);
  - FSM in SLEEP.
- FSM states: IDLE, WAIT, ERR1, ERR2, SLEEP.
- IDLE:
  - Accept + error -> ERR1.
  - Accept, OKAY, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES.
  - Accept, OKAY, WAIT_STATES=0 -> data phase completes next cycle (stay IDLE, hreadyout stays 1).
  - No accept & i_sleep_req -> SLEEP.
- WAIT:
  - o_hreadyout=0 and counter decrements each cycle.
  - When counter reaches 1, the next cycle has o_hreadyout=1 (completion); in that cycle a new accept is legal (pipelined).
  - Next state follows the IDLE rules.
- ERR1: o_hresp=1, o_hreadyout=0 -> ERR2.
- ERR2: o_hresp=1, o_hreadyout=1.
  - Any address phase presented in ERR2 is accepted normally.
  - Otherwise -> IDLE.
- Latency: an OKAY transfer takes exactly WAIT_STATES+1 data-phase cycles. An ERROR transfer takes exactly 2.
- Reads:
  - o_hrdata <= mem[index] is loaded on the accepting edge, full word regardless of hsize.
  - It holds until the next read accept; writes and errors do not change it.
- Writes:
  - Performed on the edge ending the completing data-phase cycle, using i_hwdata.
  - Byte strobes come from latched size and addr[1:0]: byte -> 1 lane, half -> lanes {1:0} or {3:2}, word -> all.
  - ERROR transfers never write.
- RAW forwarding:
  - A read accepted on the same edge that commits a write to the same word returns the merged data: new bytes in the strobed lanes, old bytes elsewhere.
- Sleep:
  - o_sleep_ack rises the cycle after entering SLEEP, which happens only with no transfer outstanding.
  - In SLEEP, any accept gives a two-cycle ERROR (SLEEP->ERR1->ERR2->SLEEP while i_sleep_req stays high).
  - Deasserting i_sleep_req -> IDLE; o_sleep_ack falls the next cycle.
- Reset mid-transfer: everything returns to reset values immediately; a pending write is dropped.
- Simultaneous i_sleep_req and accept: the accept wins and sleep is deferred until the FSM returns to IDLE.

Decomposition:
- Shared package ahb_pkg (reused by bridge sink/source):
  - HTRANS_IDLE/HTRANS_NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - sram slave state enum.
- Sub-module ahb_byte_strobe_gen: combinational, hsize + addr[1:0] -> 4-bit strobe plus misalign flag. It is used for both the write and forwarding paths.

Test Plan:
- Reset check: assert i_rstn_sink low mid-WAIT -> outputs immediately read hreadyout=1, hresp=0, hrdata=0, sleep_ack=0.
- Word write/read, WAIT_STATES=1:
  - Write 0xDEADBEEF @0x10, then read @0x10.
  - Each data phase shows exactly one hreadyout=0 cycle; the read returns 0xDEADBEEF with hresp=0.
- Byte/half lanes:
  - Write word 0x11223344 @0x20, byte 0xAA @0x21 (hwdata 0x0000AA00), half 0xBBCC @0x22 (hwdata 0xBBCC0000).
  - Read @0x20 -> 0xBBCCAA44.
- Back-to-back forwarding, WAIT_STATES=0:
  - Write 0x12345678 @0x40 immediately followed by read @0x40.
  - No stall; the read returns 0x12345678 in the following cycle.
- Errors:
  - Read @BASE_ADDR+MEM_DEPTH*4 -> hresp=1/hreadyout=0, then hresp=1/hreadyout=1.
  - Misaligned word write @0x42 -> same 2-cycle ERROR, and mem[0x40] is unchanged.
- Sleep:
  - Raise i_sleep_req while idle -> ack after 1 cycle.
  - A transfer during sleep -> 2-cycle ERROR with ack held high.
  - Drop req -> ack falls after 1 cycle; a subsequent write @0x0 completes OKAY.
